// File: rtl/fifo_ctrl_param.sv
// fifo_ctrl_param: single-clock FIFO controller for an external register-file
// datapath. It owns the write/read pointers, the occupancy count, the status
// flags and the ready/valid handshakes. Pointers wrap at DEPTH-1, so any
// DEPTH >= 2 is supported, including depths that are not a power of two.
// Optional build macro FIFO_ERR_FLAGS_EN adds sticky overflow/underflow
// diagnostic outputs.
module fifo_ctrl_param #(
  parameter int DEPTH    = 8,
  parameter int ADDR_W   = 3,
  parameter int CNT_W    = 4,
  parameter int AF_LEVEL = 6,
  parameter int AE_LEVEL = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              w_en,
  output logic              ready,
  output logic              wr_ld,
  output logic [ADDR_W-1:0] wr_addr,
  input  logic              read_en,
  output logic              valid,
  output logic              rd_ld,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              almost_empty,
  output logic [CNT_W-1:0]  count
`ifdef FIFO_ERR_FLAGS_EN
  ,
  output logic              overflow,
  output logic              underflow
`endif
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0]  FULL_CNT  = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0]  AF_CNT    = CNT_W'(AF_LEVEL);
  localparam logic [CNT_W-1:0]  AE_CNT    = CNT_W'(AE_LEVEL);

  logic wr_acc;
  logic rd_acc;

  // Status flags are pure decodes of the registered count, so they never lag it.
  always_comb begin
    full         = (count == FULL_CNT);
    empty        = (count == '0);
    almost_full  = (count >= AF_CNT);
    almost_empty = (count <= AE_CNT);
    ready        = ~full;
    valid        = ~empty;
  end

  // Accepts are qualified by the flags and suppressed under reset, since reset wins over any request.
  always_comb begin
    wr_acc = w_en & ready & ~rst;
    rd_acc = read_en & valid & ~rst;
    wr_ld  = wr_acc;
    rd_ld  = rd_acc;
  end

  // Write pointer advances on each accepted write and wraps from DEPTH-1 back to zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_addr <= '0;
    end else if (wr_acc) begin
      if (wr_addr == LAST_ADDR) begin
        wr_addr <= '0;
      end else begin
        wr_addr <= wr_addr + ADDR_W'(1);
      end
    end
  end

  // Read pointer advances on each accepted read and wraps from DEPTH-1 back to zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_addr <= '0;
    end else if (rd_acc) begin
      if (rd_addr == LAST_ADDR) begin
        rd_addr <= '0;
      end else begin
        rd_addr <= rd_addr + ADDR_W'(1);
      end
    end
  end

  // Occupancy moves only when exactly one side is accepted; a simultaneous pair cancels out.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else begin
      case ({wr_acc, rd_acc})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

`ifdef FIFO_ERR_FLAGS_EN
  // Sticky diagnostics: record any request made against a full or empty FIFO until the next reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (w_en & full) begin
        overflow <= 1'b1;
      end
      if (read_en & empty) begin
        underflow <= 1'b1;
      end
    end
  end
`else
`endif

endmodule

// File: tb/tb_fifo_ctrl_param.sv
// tb_fifo_ctrl_param: drives two controller instances (DEPTH=8 and DEPTH=5)
// with the same request stream and compares every output, every cycle,
// against a queue-occupancy reference model built from totals of accepted
// transfers.
module tb_fifo_ctrl_param;

  logic clk = 1'b0;
  logic rst;
  logic w_en;
  logic read_en;

  logic [1:0]       ready_o;
  logic [1:0]       wr_ld_o;
  logic [1:0][2:0]  wr_addr_o;
  logic [1:0]       valid_o;
  logic [1:0]       rd_ld_o;
  logic [1:0][2:0]  rd_addr_o;
  logic [1:0]       full_o;
  logic [1:0]       empty_o;
  logic [1:0]       af_o;
  logic [1:0]       ae_o;
  logic [1:0][3:0]  count_o;
`ifdef FIFO_ERR_FLAGS_EN
  logic [1:0]       ovf_o;
  logic [1:0]       unf_o;
`endif

  int depth [2] = '{8, 5};
  int af_lvl[2] = '{6, 4};
  int ae_lvl[2] = '{2, 1};

  int m_cnt [2];
  int m_wtot[2];
  int m_rtot[2];
  int m_ovf [2];
  int m_unf [2];
  bit model_known = 1'b0;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  fifo_ctrl_param #(
    .DEPTH(8), .ADDR_W(3), .CNT_W(4), .AF_LEVEL(6), .AE_LEVEL(2)
  ) dut8 (
    .clk(clk), .rst(rst), .w_en(w_en), .ready(ready_o[0]), .wr_ld(wr_ld_o[0]),
    .wr_addr(wr_addr_o[0]), .read_en(read_en), .valid(valid_o[0]), .rd_ld(rd_ld_o[0]),
    .rd_addr(rd_addr_o[0]), .full(full_o[0]), .empty(empty_o[0]),
    .almost_full(af_o[0]), .almost_empty(ae_o[0]), .count(count_o[0])
`ifdef FIFO_ERR_FLAGS_EN
    , .overflow(ovf_o[0]), .underflow(unf_o[0])
`endif
  );

  fifo_ctrl_param #(
    .DEPTH(5), .ADDR_W(3), .CNT_W(4), .AF_LEVEL(4), .AE_LEVEL(1)
  ) dut5 (
    .clk(clk), .rst(rst), .w_en(w_en), .ready(ready_o[1]), .wr_ld(wr_ld_o[1]),
    .wr_addr(wr_addr_o[1]), .read_en(read_en), .valid(valid_o[1]), .rd_ld(rd_ld_o[1]),
    .rd_addr(rd_addr_o[1]), .full(full_o[1]), .empty(empty_o[1]),
    .almost_full(af_o[1]), .almost_empty(ae_o[1]), .count(count_o[1])
`ifdef FIFO_ERR_FLAGS_EN
    , .overflow(ovf_o[1]), .underflow(unf_o[1])
`endif
  );

  // Single comparison point: counts every check and reports any mismatch.
  task automatic checkOutput(input string tag, input int actual, input int expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s actual=%0d expected=%0d (t=%0t)", tag, actual, expected, $time);
    end
  endtask

  // Compare all outputs of one instance with what the model predicts for the current inputs.
  task automatic checkDut(input int k);
    string p;
    int    c;
    bit    mfull;
    bit    mempty;
    p      = (k == 0) ? "d8" : "d5";
    c      = m_cnt[k];
    mfull  = (c == depth[k]);
    mempty = (c == 0);
    checkOutput({p, ".count"},        int'(count_o[k]),   c);
    checkOutput({p, ".wr_addr"},      int'(wr_addr_o[k]), m_wtot[k] % depth[k]);
    checkOutput({p, ".rd_addr"},      int'(rd_addr_o[k]), m_rtot[k] % depth[k]);
    checkOutput({p, ".full"},         int'(full_o[k]),    int'(mfull));
    checkOutput({p, ".empty"},        int'(empty_o[k]),   int'(mempty));
    checkOutput({p, ".ready"},        int'(ready_o[k]),   int'(!mfull));
    checkOutput({p, ".valid"},        int'(valid_o[k]),   int'(!mempty));
    checkOutput({p, ".almost_full"},  int'(af_o[k]),      int'(c >= af_lvl[k]));
    checkOutput({p, ".almost_empty"}, int'(ae_o[k]),      int'(c <= ae_lvl[k]));
    checkOutput({p, ".wr_ld"},        int'(wr_ld_o[k]),   int'(w_en && !mfull && !rst));
    checkOutput({p, ".rd_ld"},        int'(rd_ld_o[k]),   int'(read_en && !mempty && !rst));
`ifdef FIFO_ERR_FLAGS_EN
    checkOutput({p, ".overflow"},     int'(ovf_o[k]),     m_ovf[k]);
    checkOutput({p, ".underflow"},    int'(unf_o[k]),     m_unf[k]);
`endif
  endtask

  // Advance the reference model by one clock edge for the given inputs.
  task automatic modelEdge(input int k, input bit w, input bit r, input bit rs);
    bit wa;
    bit ra;
    if (rs) begin
      m_cnt[k] = 0; m_wtot[k] = 0; m_rtot[k] = 0; m_ovf[k] = 0; m_unf[k] = 0;
    end else begin
      wa = w && (m_cnt[k] != depth[k]);
      ra = r && (m_cnt[k] != 0);
      if (w && m_cnt[k] == depth[k]) m_ovf[k] = 1;
      if (r && m_cnt[k] == 0) m_unf[k] = 1;
      m_wtot[k] += int'(wa);
      m_rtot[k] += int'(ra);
      m_cnt[k]  += int'(wa) - int'(ra);
    end
  endtask

  // One cycle: drive at the falling edge, check shortly after, then step the model at the rising edge.
  task automatic applyStimulus(input bit w, input bit r, input bit rs);
    @(negedge clk);
    w_en    = w;
    read_en = r;
    rst     = rs;
    #1;
    if (model_known) begin
      checkDut(0);
      checkDut(1);
    end
    @(posedge clk);
    modelEdge(0, w, r, rs);
    modelEdge(1, w, r, rs);
    if (rs) model_known = 1'b1;
  endtask

  initial begin
    rst = 1'b1; w_en = 1'b1; read_en = 1'b1;

    applyStimulus(1, 1, 1);
    applyStimulus(1, 1, 1);
    applyStimulus(0, 0, 0);

    for (int i = 0; i < 9; i++) applyStimulus(1, 0, 0);
    for (int i = 0; i < 9; i++) applyStimulus(0, 1, 0);

    for (int i = 0; i < 8; i++) applyStimulus(1, 0, 0);
    applyStimulus(1, 1, 0);
    for (int i = 0; i < 20 && m_cnt[0] != 0; i++) applyStimulus(0, 1, 0);
    applyStimulus(1, 1, 0);
    for (int i = 0; i < 3; i++) applyStimulus(1, 0, 0);
    applyStimulus(1, 1, 0);
    applyStimulus(0, 0, 0);

    applyStimulus(0, 0, 1);
    for (int i = 0; i < 24; i++) applyStimulus(1, (i % 3) == 2, 0);
    for (int i = 0; i < 6; i++) applyStimulus(1, 1, 0);

    for (int i = 0; i < 400; i++) begin
      applyStimulus(1'($urandom_range(0, 99) < 55),
                    1'($urandom_range(0, 99) < 45),
                    1'($urandom_range(0, 99) < 2));
    end

    applyStimulus(0, 0, 1);
    applyStimulus(0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
